rst_seq_ctrl: RTL
=================

// Module: rst_seq_ctrl
// PURPOSE
//   Synthesizable reset sequencer for NumDomains reset domains on one clock.
//   After power-on reset, holds every domain in reset, then releases the domains
//   in order 0..N-1 with a fixed gap between releases.
//   Software can re-reset all domains at run time through a four-phase req/ack handshake.
//   Sits between the top-level reset (a clock/reset generator in benches, a pad in silicon)
//   and the subsystem resets.
// PARAMETERS
//   NumDomains   4   number of sequenced reset domains (>=1)
//   AssertHold   8   cycles all domains stay in reset before release starts (>=1)
//   ReleaseDelay 16  cycles between consecutive domain releases (>=1)
//   CntWidth     $clog2(max(AssertHold,ReleaseDelay)+1)  internal counter width (derived)
// PORTS
//   clk_i          in   1                          clock
//   rst_ni         in   1                          async active-low reset
//   sw_rst_req_i   in   1                          software reset request (level, 4-phase)
//   sw_rst_ack_o   out  1                          request acknowledged; all domains held in reset
//   domain_rst_no  out  NumDomains                 per-domain active-low reset, registered
//   stage_o        out  $clog2(NumDomains+1)       number of domains currently released
//   busy_o         out  1                          sequence in progress (not RUN)
//   done_o         out  1                          all domains released (RUN)
// BEHAVIOUR
//   - Clock/reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
//   - rst_ni low, asynchronously and mid-operation: domain_rst_no='0, sw_rst_ack_o=0, stage_o=0,
//     busy_o=1, done_o=0, state=ASSERT, counter=0.
//   - Timing: "edge k" = k-th rising clk_i edge after rst_ni deasserts.
//     Every output is a flop and changes only just after an edge.
//   - FSM states: ASSERT, HOLD, RELEASE, RUN (plus ASSERT_SEQ, only with the optional feature).
//   - ASSERT: all domains low. Counter counts AssertHold edges. On the final edge:
//     -> HOLD if sw_rst_req_i=1 (sw_rst_ack_o=1 after that edge); otherwise -> RELEASE.
//   - HOLD: all domains low, ack=1. Edge sampling req=0 -> ack=0, -> RELEASE, counter cleared.
//   - RELEASE: every ReleaseDelay edges, release the next domain (rst_no bit i=1) and set stage_o=i+1.
//     Domain N-1 release edge: -> RUN; done_o=1 and busy_o=0 after that same edge.
//   - Power-on example (N=4, AH=8, RD=16): domains released after edges 24/40/56/72; done_o after edge 72.
//   - RUN: req sampled 1 at edge t -> after edge t: all domains low, stage_o=0, busy_o=1,
//     done_o=0, state ASSERT. Ack rises after edge t+AssertHold.
//   - req dropped while in ASSERT (before ack): hold completes, then RELEASE; ack never rises.
//   - req asserted during RELEASE: ignored until RUN; no partial re-reset.
//   - Domains, once released, stay released until RUN+req or rst_ni; never glitch (registered).
//   - Counter saturates to no wrap; it is cleared on every state change.
//   - Non-synthesis assertions:
//     - NumDomains, AssertHold, ReleaseDelay >= 1 ($fatal at elaboration).
//     - sw_rst_req_i does not fall while ack=0 in HOLD (protocol).
// CONFIGURATION
//   - RST_SEQ_REVERSE_ASSERT_EN defined: run-time re-reset asserts domains in reverse order.
//     RUN+req at edge t -> state ASSERT_SEQ; domain N-1 low after edge t, domain N-2 after
//     t+RD, ..., domain 0 after t+(N-1)*RD. stage_o decrements with each assertion.
//     Then ASSERT hold of AssertHold edges, with the same HOLD/RELEASE rules.
//   - Undefined: all domains assert together after edge t; ASSERT_SEQ absent.
//   - Power-on and async reset always assert all domains at once, either way.
// TESTING
//   - Power-on, N=4/AH=8/RD=16, req=0 -> rst_no bits rise after edges 24,40,56,72;
//     stage_o 1..4; done_o=1 after edge 72.
//   - In RUN, req=1 at edge 100, held -> all rst_no=0 after 100; ack=1 after 108;
//     req=0 at 120 -> ack=0 after 120; domain0 up after 136, done after 184.
//   - req pulse 1 cycle at edge 100 -> rst_no=0 after 100; ack stays 0;
//     release starts; domain0 up after 124.
//   - rst_ni pulsed low mid-RELEASE (stage_o=2) -> all outputs at reset values immediately;
//     full power-on sequence restarts.
//   - With RST_SEQ_REVERSE_ASSERT_EN, req at edge 100 -> domain3 low after 100, d2 after 116,
//     d1 after 132, d0 after 148; ack after 156.
//   - N=1, AH=1, RD=1 -> domain0 up after edge 2; req at edge 10 -> ack after edge 11.

Source files
------------

// File: rtl/rst_seq_ctrl_if.sv
// Handshake and reset-fanout bundle of the reset sequencer.
// The sequencer connects through the slave modport; the requesting side uses master.
interface rst_seq_ctrl_if #(
  parameter int NumDomains = 4
);
  localparam int StageWidth = $clog2(NumDomains + 1);

  logic                  sw_rst_req_i;
  logic                  sw_rst_ack_o;
  logic [NumDomains-1:0] domain_rst_no;
  logic [StageWidth-1:0] stage_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output sw_rst_req_i,
    input  sw_rst_ack_o, domain_rst_no, stage_o, busy_o, done_o
  );

  modport slave (
    input  sw_rst_req_i,
    output sw_rst_ack_o, domain_rst_no, stage_o, busy_o, done_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds NumDomains resets low, then releases them in order 0..N-1.
// Define RST_SEQ_REVERSE_ASSERT_EN to assert domains N-1..0 one by one on a software re-reset.
module rst_seq_ctrl #(
  parameter int NumDomains   = 4,
  parameter int AssertHold   = 8,
  parameter int ReleaseDelay = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  rst_seq_ctrl_if.slave bus
);
  localparam int CntMax     = (AssertHold > ReleaseDelay) ? AssertHold : ReleaseDelay;
  localparam int CntWidth   = $clog2(CntMax + 1);
  localparam int StageWidth = $clog2(NumDomains + 1);

  localparam logic [CntWidth-1:0]   HoldLast  = CntWidth'(AssertHold - 1);
  localparam logic [CntWidth-1:0]   RelLast   = CntWidth'(ReleaseDelay - 1);
  localparam logic [CntWidth-1:0]   CntSat    = CntWidth'(CntMax);
  localparam logic [StageWidth-1:0] LastStage = StageWidth'(NumDomains - 1);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    , ST_ASSERT_SEQ = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NumDomains-1:0] dom_q, dom_d;
  logic [StageWidth-1:0] stage_q, stage_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Saturate rather than wrap so a long HOLD or RUN never re-arms a terminal count.
  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntWidth'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_inc;
    dom_d   = dom_q;
    stage_d = stage_q;
    ack_d   = ack_q;

    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if (bus.sw_rst_req_i) begin
            state_d = ST_HOLD;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end

      ST_HOLD: begin
        if (!bus.sw_rst_req_i) begin
          state_d = ST_RELEASE;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == RelLast) begin
          cnt_d = '0;
          for (int i = 0; i < NumDomains; i++) begin
            if (StageWidth'(i) == stage_q) dom_d[i] = 1'b1;
          end
          stage_d = stage_q + StageWidth'(1);
          if (stage_q == LastStage) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.sw_rst_req_i) begin
          cnt_d = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          dom_d[NumDomains-1] = 1'b0;
          stage_d = LastStage;
          state_d = (NumDomains == 1) ? ST_ASSERT : ST_ASSERT_SEQ;
`else
          dom_d   = '0;
          stage_d = '0;
          state_d = ST_ASSERT;
`endif
        end
      end

`ifdef RST_SEQ_REVERSE_ASSERT_EN
      ST_ASSERT_SEQ: begin
        // stage_q equals the count of domains still running, so domain stage_q-1 goes next.
        if (cnt_q == RelLast) begin
          cnt_d = '0;
          for (int i = 0; i < NumDomains; i++) begin
            if (StageWidth'(i + 1) == stage_q) dom_d[i] = 1'b0;
          end
          stage_d = stage_q - StageWidth'(1);
          if (stage_q == StageWidth'(1)) state_d = ST_ASSERT;
        end
      end
`endif

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        dom_d   = '0;
        stage_d = '0;
        ack_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_RUN);
    done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      dom_q   <= '0;
      stage_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.domain_rst_no = dom_q;
  assign bus.stage_o       = stage_q;
  assign bus.sw_rst_ack_o  = ack_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

`ifndef SYNTHESIS
  if (NumDomains < 1 || AssertHold < 1 || ReleaseDelay < 1) begin : g_bad_params
    $fatal(1, "rst_seq_ctrl: NumDomains, AssertHold and ReleaseDelay must all be >= 1");
  end

  a_req_held_in_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_HOLD && !ack_q) |-> bus.sw_rst_req_i)
    else $error("rst_seq_ctrl: sw_rst_req_i fell in HOLD before acknowledge");
`endif
endmodule
